// File: rtl/muldiv_ctrl.sv
// Iterative radix-2 multiply/divide sequencer driving the HI/LO write port.
// Define MULDIV_DIV_EN to build the divide datapath; otherwise div/divu are no-ops.
module muldiv_ctrl #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             md_start_i,
  input  logic [1:0]       md_op_i,
  input  logic [WIDTH-1:0] md_src1_i,
  input  logic [WIDTH-1:0] md_src2_i,
  input  logic             flush_i,
  output logic             stall_req_o,
  output logic             busy_o,
  output logic             whilo_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_neg_q;
  logic [WIDTH-1:0]   r_opb;
  logic [2*WIDTH-1:0] r_acc;
  logic               r_whilo;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;

  logic               w_start;
  logic               w_a_neg;
  logic               w_b_neg;
  logic [WIDTH-1:0]   w_a_mag;
  logic [WIDTH-1:0]   w_b_mag;
  logic [WIDTH:0]     w_mul_sum;
  logic [2*WIDTH-1:0] w_mul_next;
  logic [2*WIDTH-1:0] w_acc_next;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_res_hi;
  logic [WIDTH-1:0]   w_res_lo;

  // md_op_i[0]=0 selects the signed variants
  assign w_a_neg = ~md_op_i[0] & md_src1_i[WIDTH-1];
  assign w_b_neg = ~md_op_i[0] & md_src2_i[WIDTH-1];
  assign w_a_mag = w_a_neg ? -md_src1_i : md_src1_i;
  assign w_b_mag = w_b_neg ? -md_src2_i : md_src2_i;

  // Shift-add: multiplier sits in the low half, carry of the add shifts into bit 63
  assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opb} : '0);
  assign w_mul_next = {w_mul_sum, r_acc[WIDTH-1:1]};
  assign w_prod     = r_neg_q ? -w_acc_next : w_acc_next;

`ifdef MULDIV_DIV_EN
  logic               r_is_div;
  logic               r_neg_r;
  logic               r_dz;
  logic [WIDTH:0]     w_div_diff;
  logic [2*WIDTH-1:0] w_div_next;
  logic [WIDTH-1:0]   w_quot;
  logic [WIDTH-1:0]   w_rem;

  assign w_start = md_start_i & ~flush_i;

  // Remainder stays below the divisor, so the shifted partial fits in WIDTH+1 bits
  // and bit WIDTH of the difference is the borrow.
  assign w_div_diff = r_acc[2*WIDTH-1:WIDTH-1] - {1'b0, r_opb};
  assign w_div_next = w_div_diff[WIDTH] ? {r_acc[2*WIDTH-2:0], 1'b0}
                                        : {w_div_diff[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};
  assign w_acc_next = r_is_div ? w_div_next : w_mul_next;
  assign w_quot     = w_acc_next[WIDTH-1:0];
  assign w_rem      = w_acc_next[2*WIDTH-1:WIDTH];

  // Divide by zero yields an all-ones quotient regardless of operand signs
  always_comb begin
    w_res_hi = w_prod[2*WIDTH-1:WIDTH];
    w_res_lo = w_prod[WIDTH-1:0];
    if (r_is_div) begin
      w_res_hi = r_neg_r ? -w_rem : w_rem;
      w_res_lo = r_dz ? '1 : (r_neg_q ? -w_quot : w_quot);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_is_div <= 1'b0;
      r_neg_r  <= 1'b0;
      r_dz     <= 1'b0;
    end else if (r_state == StIdle && w_start) begin
      r_is_div <= md_op_i[1];
      r_neg_r  <= w_a_neg;
      r_dz     <= md_op_i[1] & (md_src2_i == '0);
    end
  end
`else
  assign w_start    = md_start_i & ~flush_i & ~md_op_i[1];
  assign w_acc_next = w_mul_next;
  assign w_res_hi   = w_prod[2*WIDTH-1:WIDTH];
  assign w_res_lo   = w_prod[WIDTH-1:0];
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= StIdle;
      r_cnt   <= '0;
      r_neg_q <= 1'b0;
      r_opb   <= '0;
      r_acc   <= '0;
      r_whilo <= 1'b0;
      r_hi    <= '0;
      r_lo    <= '0;
    end else begin
      r_whilo <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (w_start) begin
            r_state <= StBusy;
            r_cnt   <= '0;
            r_neg_q <= w_a_neg ^ w_b_neg;
`ifdef MULDIV_DIV_EN
            if (md_op_i[1]) begin
              r_acc <= {{WIDTH{1'b0}}, w_a_mag};
              r_opb <= w_b_mag;
            end else begin
              r_acc <= {{WIDTH{1'b0}}, w_b_mag};
              r_opb <= w_a_mag;
            end
`else
            r_acc <= {{WIDTH{1'b0}}, w_b_mag};
            r_opb <= w_a_mag;
`endif
          end
        end
        StBusy: begin
          if (flush_i) begin
            r_state <= StIdle;
          end else begin
            r_acc <= w_acc_next;
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == CNT_W'(WIDTH - 1)) begin
              r_state <= StDone;
              r_whilo <= 1'b1;
              r_hi    <= w_res_hi;
              r_lo    <= w_res_lo;
            end
          end
        end
        StDone:  r_state <= StIdle;
        default: r_state <= StIdle;
      endcase
    end
  end

  assign stall_req_o = ((r_state == StIdle) & w_start) | ((r_state == StBusy) & ~flush_i);
  assign busy_o      = (r_state == StBusy);
  assign whilo_o     = r_whilo & ~flush_i;
  assign hi_o        = r_hi;
  assign lo_o        = r_lo;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Self-checking bench for muldiv_ctrl: scoreboard of expected HI/LO writes plus
// per-scenario timing checks. Divide scenarios depend on MULDIV_DIV_EN.
module tb_muldiv_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        md_start_i;
  logic [1:0]  md_op_i;
  logic [31:0] md_src1_i;
  logic [31:0] md_src2_i;
  logic        flush_i;
  logic        stall_req_o;
  logic        busy_o;
  logic        whilo_o;
  logic [31:0] hi_o;
  logic [31:0] lo_o;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
  } res_t;

  res_t        exp_q[$];
  res_t        mon_e;
  int          n_checks = 0;
  int          n_errors = 0;
  int          n_whilo  = 0;
  logic [31:0] last_hi  = '0;
  logic [31:0] last_lo  = '0;

  muldiv_ctrl #(
    .WIDTH(32),
    .CNT_W(6)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .md_start_i (md_start_i),
    .md_op_i    (md_op_i),
    .md_src1_i  (md_src1_i),
    .md_src2_i  (md_src2_i),
    .flush_i    (flush_i),
    .stall_req_o(stall_req_o),
    .busy_o     (busy_o),
    .whilo_o    (whilo_o),
    .hi_o       (hi_o),
    .lo_o       (lo_o)
  );

  always #5 clk = ~clk;

  // Scoreboard: every HI/LO write must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (whilo_o === 1'b1) begin
      n_whilo++;
      n_checks++;
      if (exp_q.size() == 0) begin
        n_errors++;
        $display("FAIL whilo_unexpected got hi=%h lo=%h expected no write", hi_o, lo_o);
      end else begin
        mon_e = exp_q.pop_front();
        if (hi_o !== mon_e.hi || lo_o !== mon_e.lo) begin
          n_errors++;
          $display("FAIL hilo_result got hi=%h lo=%h expected hi=%h lo=%h",
                   hi_o, lo_o, mon_e.hi, mon_e.lo);
        end
        last_hi = mon_e.hi;
        last_lo = mon_e.lo;
      end
    end
  end

  function automatic res_t model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    res_t        r;
    logic [63:0] p;
    case (op)
      2'b00: begin
        p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
        r = p;
      end
      2'b01: begin
        p = {32'b0, a} * {32'b0, b};
        r = p;
      end
      2'b10: begin
        if (b == 0) r = '{hi: a, lo: 32'hFFFF_FFFF};
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = '{hi: 32'h0, lo: a};
        else r = '{hi: $signed(a) % $signed(b), lo: $signed(a) / $signed(b)};
      end
      default: begin
        if (b == 0) r = '{hi: a, lo: 32'hFFFF_FFFF};
        else r = '{hi: a % b, lo: a / b};
      end
    endcase
    return r;
  endfunction

  task automatic idle(input int n);
    @(posedge clk); #1;
    md_start_i = 1'b0;
    flush_i    = 1'b0;
    rst        = 1'b0;
    repeat (n) @(posedge clk);
  endtask

  // Issue on the next cycle and hold start until the DONE cycle (left held on return)
  task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] eh, input logic [31:0] el);
    int cnt;
    @(posedge clk); #1;
    md_start_i = 1'b1;
    md_op_i    = op;
    md_src1_i  = a;
    md_src2_i  = b;
    exp_q.push_back('{hi: eh, lo: el});
    cnt = 0;
    @(negedge clk);
    while (stall_req_o === 1'b1 && cnt < 100) begin
      cnt++;
      @(negedge clk);
    end
    n_checks++;
    if (cnt != 33) begin
      n_errors++;
      $display("FAIL stall_len op=%b got %0d cycles expected 33", op, cnt);
    end
    n_checks++;
    if (whilo_o !== 1'b1) begin
      n_errors++;
      $display("FAIL whilo_after_stall op=%b got %b expected 1", op, whilo_o);
    end
  endtask

  task automatic check_quiet(input string name);
    n_checks++;
    if (stall_req_o !== 1'b0 || busy_o !== 1'b0 || whilo_o !== 1'b0) begin
      n_errors++;
      $display("FAIL %s got stall=%b busy=%b whilo=%b expected 0 0 0",
               name, stall_req_o, busy_o, whilo_o);
    end
  endtask

  task automatic test_reset;
    rst        = 1'b1;
    md_start_i = 1'b0;
    md_op_i    = 2'b00;
    md_src1_i  = '0;
    md_src2_i  = '0;
    flush_i    = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_quiet("reset_ctrl");
    n_checks++;
    if (hi_o !== 32'h0 || lo_o !== 32'h0) begin
      n_errors++;
      $display("FAIL reset_hilo got hi=%h lo=%h expected 0 0", hi_o, lo_o);
    end
  endtask

  task automatic test_mult;
    res_t        r;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    do_op(2'b00, 32'h0000_0003, 32'hFFFF_FFFC, 32'hFFFF_FFFF, 32'hFFFF_FFF4);
    idle(2);
    do_op(2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0);
    idle(1);
    for (int i = 0; i < 4; i++) begin
      op = 2'(i % 2);
      a  = $urandom;
      b  = $urandom;
      r  = model(op, a, b);
      do_op(op, a, b, r.hi, r.lo);
      idle(1);
    end
  endtask

  task automatic test_back_to_back;
    do_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    do_op(2'b01, 32'd2, 32'd3, 32'h0, 32'd6);
    idle(2);
  endtask

`ifdef MULDIV_DIV_EN
  task automatic test_div;
    res_t        r;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    do_op(2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    idle(1);
    do_op(2'b11, 32'd100, 32'd7, 32'd2, 32'd14);
    idle(1);
    do_op(2'b11, 32'h1234_5678, 32'h0, 32'h1234_5678, 32'hFFFF_FFFF);
    idle(1);
    do_op(2'b10, 32'hFFFF_FFF9, 32'h0, 32'hFFFF_FFF9, 32'hFFFF_FFFF);
    idle(1);
    do_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000);
    idle(1);
    for (int i = 0; i < 4; i++) begin
      op = 2'(2 + (i % 2));
      a  = $urandom;
      b  = $urandom_range(1, 32'h0001_0000) ^ ((i > 1) ? 32'h8000_0000 : 32'h0);
      r  = model(op, a, b);
      do_op(op, a, b, r.hi, r.lo);
      idle(1);
    end
  endtask
`else
  task automatic test_div_disabled;
    int prev;
    prev = n_whilo;
    @(posedge clk); #1;
    md_start_i = 1'b1;
    md_op_i    = 2'b10;
    md_src1_i  = 32'hFFFF_FFF9;
    md_src2_i  = 32'h0000_0002;
    for (int i = 0; i < 6; i++) begin
      if (i == 3) md_op_i = 2'b11;
      @(negedge clk);
      check_quiet("div_disabled");
    end
    idle(40);
    n_checks++;
    if (n_whilo != prev) begin
      n_errors++;
      $display("FAIL div_disabled_whilo got %0d writes expected 0", n_whilo - prev);
    end
  endtask
`endif

  task automatic test_flush;
    int prev;
    prev = n_whilo;
    // Flush in IDLE suppresses the start
    @(posedge clk); #1;
    md_start_i = 1'b1;
    md_op_i    = 2'b00;
    md_src1_i  = 32'd7;
    md_src2_i  = 32'd9;
    flush_i    = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check_quiet("flush_idle");
    end
    // Flush at BUSY cycle 10
    @(posedge clk); #1 flush_i = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    flush_i    = 1'b1;
    md_start_i = 1'b0;
    @(negedge clk);
    n_checks++;
    if (stall_req_o !== 1'b0) begin
      n_errors++;
      $display("FAIL flush_busy_stall got %b expected 0", stall_req_o);
    end
    @(posedge clk); #1 flush_i = 1'b0;
    @(negedge clk);
    check_quiet("flush_after");
    repeat (40) @(negedge clk);
    n_checks++;
    if (n_whilo != prev) begin
      n_errors++;
      $display("FAIL flush_whilo got %0d writes expected 0", n_whilo - prev);
    end
    n_checks++;
    if (hi_o !== last_hi || lo_o !== last_lo) begin
      n_errors++;
      $display("FAIL flush_hilo_hold got hi=%h lo=%h expected hi=%h lo=%h",
               hi_o, lo_o, last_hi, last_lo);
    end
  endtask

  task automatic test_reset_midop;
    int prev;
    prev = n_whilo;
    @(posedge clk); #1;
    md_start_i = 1'b1;
    md_op_i    = 2'b00;
    md_src1_i  = 32'd11;
    md_src2_i  = 32'd13;
    repeat (20) @(posedge clk);
    #1;
    rst        = 1'b1;
    md_start_i = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check_quiet("rst_midop_ctrl");
    n_checks++;
    if (hi_o !== 32'h0 || lo_o !== 32'h0) begin
      n_errors++;
      $display("FAIL rst_midop_hilo got hi=%h lo=%h expected 0 0", hi_o, lo_o);
    end
    last_hi = '0;
    last_lo = '0;
    repeat (40) @(negedge clk);
    n_checks++;
    if (n_whilo != prev) begin
      n_errors++;
      $display("FAIL rst_midop_whilo got %0d writes expected 0", n_whilo - prev);
    end
    do_op(2'b00, 32'd5, 32'd5, 32'h0, 32'd25);
    idle(2);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_mult();
    test_back_to_back();
`ifdef MULDIV_DIV_EN
    test_div();
`else
    test_div_disabled();
`endif
    test_flush();
    test_reset_midop();
    idle(3);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL missing_writes got %0d outstanding expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
